// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-clock divider, h/v counters and a registered DAC output stage.
// Syncs, blank and colour lag DrawX/DrawY by one pixel; free-running, no backpressure.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Pix_R,
  input  logic [7:0] Pix_G,
  input  logic [7:0] Pix_B,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       PixEn,
  output logic       VGA_Clk,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_Blank_n,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       FrameStart,
  output logic [7:0] FrameCount
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]    V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]    HS_BEG   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]    HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]    VS_BEG   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]    VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic          vclk_q, vclk_d;
  logic [9:0]    hc_q, hc_d, vc_q, vc_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          fs_q, fs_d;
  logic [7:0]    fc_q, fc_d;
  logic          pix_en, visible;

  always_comb begin
    pix_en    = (div_q == DIV_LAST);
    div_d     = pix_en ? '0 : div_q + 1'b1;
    // Registered from the next divider value so VGA_Clk tracks div_cnt exactly, glitch-free.
    vclk_d    = (div_d >= DIV_HALF);
    visible   = (hc_q < H_VIS) && (vc_q < V_VIS);
    hc_d      = hc_q;
    vc_d      = vc_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    fs_d      = 1'b0;
    fc_d      = fc_q;
    if (pix_en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
      blank_n_d = visible;
      rgb_d     = visible ? {Pix_R, Pix_G, Pix_B} : '0;
      hs_d      = !((hc_q >= HS_BEG) && (hc_q < HS_END));
      vs_d      = !((vc_q >= VS_BEG) && (vc_q < VS_END));
      if ((hc_q == H_LAST) && (vc_q == V_LAST)) begin
        fs_d = 1'b1;
        fc_d = fc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q     <= '0;
      vclk_q    <= 1'b0;
      hc_q      <= '0;
      vc_q      <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
      fs_q      <= 1'b0;
      fc_q      <= '0;
    end else begin
      div_q     <= div_d;
      vclk_q    <= vclk_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
      fs_q      <= fs_d;
      fc_q      <= fc_d;
    end
  end

  assign PixEn       = pix_en;
  assign VGA_Clk     = vclk_q;
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_Blank_n = blank_n_q;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign FrameStart  = fs_q;
  assign FrameCount  = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (15x8 pixels, CLK_DIV=2, 240 Clk per frame).
// A cycle-count model predicts every output each cycle; directed literals pin the model.
module tb_vga_timing_gen;
  localparam int CD = 2;
  localparam int HV = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VV = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] Pix_R, Pix_G, Pix_B;
  logic [9:0] DrawX, DrawY;
  logic       PixEn, VGA_Clk, VGA_HS, VGA_VS, VGA_Blank_n, FrameStart;
  logic [7:0] VGA_R, VGA_G, VGA_B, FrameCount;

  int          tests = 0;
  int          fails = 0;
  int unsigned k = 0;
  longint      cyc = 0;

  assign Pix_R = mode ? DrawX[7:0] : 8'hd7;
  assign Pix_G = 8'h1c;
  assign Pix_B = 8'h1c;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Pix_R(Pix_R), .Pix_G(Pix_G), .Pix_B(Pix_B),
    .DrawX(DrawX), .DrawY(DrawY), .PixEn(PixEn), .VGA_Clk(VGA_Clk),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_Blank_n(VGA_Blank_n),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .FrameStart(FrameStart), .FrameCount(FrameCount)
  );

  always #5 Clk = ~Clk;

  // k = Clk edges since the last reset release; the whole raster is a function of k.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) k <= 0;
    else          k <= k + 1;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin : model
    int unsigned div, p, q, hq, vq;
    bit          vis;
    logic [57:0] act, exp;
    logic        e_hs, e_vs, e_bn, e_fs;
    logic [23:0] e_rgb;
    div = k % CD;
    p   = k / CD;
    e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_rgb = '0;
    if (p > 0) begin
      q    = p - 1;
      hq   = q % HT;
      vq   = (q / HT) % VT;
      vis  = (hq < HV) && (vq < VV);
      e_bn = vis;
      e_hs = !(hq >= HV + HF && hq < HV + HF + HSW);
      e_vs = !(vq >= VV + VF && vq < VV + VF + VSW);
      if (vis) e_rgb = {(mode ? 8'(hq) : 8'hd7), 8'h1c, 8'h1c};
    end
    e_fs = (p > 0) && (div == 0) && (p % FRAME == 0);
    exp = {10'(p % HT), 10'((p / HT) % VT), div == CD - 1, div >= CD / 2,
           e_hs, e_vs, e_bn, e_rgb, e_fs, 8'((p / FRAME) % 256)};
    act = {DrawX, DrawY, PixEn, VGA_Clk, VGA_HS, VGA_VS, VGA_Blank_n,
           VGA_R, VGA_G, VGA_B, FrameStart, FrameCount};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL model k=%0d: got %h, expected %h", k, act, exp);
    end
  end

  task automatic wait_xy(input int x, input int y);
    int n = 0;
    while (!(DrawX == 10'(x) && DrawY == 10'(y)) && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    chk("wait_xy reached", longint'(n < 2000), 1);
  endtask

  function automatic logic sel(input int s);
    case (s)
      0:       return VGA_HS;
      1:       return VGA_VS;
      2:       return FrameStart;
      default: return FrameCount == 8'd255;
    endcase
  endfunction

  task automatic wait_sig(input int s, input logic lvl, input int budget);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (sel(s) !== lvl && n < budget);
    chk("wait_sig reached", longint'(sel(s) === lvl), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t;
    int     n;
    repeat (5) @(negedge Clk);
    chk("reset DrawX", DrawX, 0);
    chk("reset DrawY", DrawY, 0);
    chk("reset HS", VGA_HS, 1);
    chk("reset VS", VGA_VS, 1);
    chk("reset Blank_n", VGA_Blank_n, 0);
    chk("reset RGB", {VGA_R, VGA_G, VGA_B}, 0);
    #1 Reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      chk("PixEn cadence", PixEn, (i % 2 == 0) ? 1 : 0);
      if (i == 1) chk("DrawX after first strobe", DrawX, 1);
    end

    // Hsync: falls HV+HF+1 = 11 strobes after DrawX=0, low 3 px = 6 Clk, line 30 Clk
    wait_xy(0, 1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (PixEn) n++;
      @(negedge Clk);
      if (!VGA_HS) break;
    end
    chk("HS fall strobes", n, 11);
    t = cyc;
    wait_sig(0, 1'b1, 200);
    chk("HS low width", cyc - t, 6);
    wait_sig(0, 1'b0, 200);
    chk("line period", cyc - t, 30);

    // Vsync: low on lines 5..6 = 60 Clk
    wait_sig(1, 1'b0, 1000);
    chk("VS first line", DrawY, 5);
    t = cyc;
    wait_sig(1, 1'b1, 1000);
    chk("VS low width", cyc - t, 60);

    // Frame strobe: one Clk wide, every 240 Clk
    wait_sig(2, 1'b1, 1000);
    t = cyc;
    @(negedge Clk);
    chk("FrameStart width", FrameStart, 0);
    wait_sig(2, 1'b1, 1000);
    chk("frame period", cyc - t, 240);

    // Colour pass-through and blanking
    wait_xy(3, 1);
    chk("visible R", VGA_R, 8'hd7);
    chk("visible G", VGA_G, 8'h1c);
    chk("visible B", VGA_B, 8'h1c);
    chk("visible Blank_n", VGA_Blank_n, 1);
    wait_xy(9, 1);
    chk("h-blank R", VGA_R, 0);
    chk("h-blank Blank_n", VGA_Blank_n, 0);
    wait_xy(3, 5);
    chk("v-blank RGB", {VGA_R, VGA_G, VGA_B}, 0);

    // FrameCount wrap 255 -> 0
    wait_sig(3, 1'b1, 70000);
    wait_sig(2, 1'b1, 1000);
    chk("FrameCount wrap", FrameCount, 0);

    // Mid-frame reset inside both sync pulses
    wait_xy(12, 6);
    chk("pre-reset HS", VGA_HS, 0);
    chk("pre-reset VS", VGA_VS, 0);
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    mode = 1'b1;
    #1;
    chk("mid-reset HS", VGA_HS, 1);
    chk("mid-reset VS", VGA_VS, 1);
    chk("mid-reset DrawX", DrawX, 0);
    chk("mid-reset DrawY", DrawY, 0);
    chk("mid-reset FrameCount", FrameCount, 0);
    repeat (3) @(negedge Clk);
    #1 Reset_n = 1'b1;
    t = cyc;

    // Alignment: VGA_R shows the previous DrawX
    wait_xy(5, 0);
    chk("align R x=4", VGA_R, 4);
    wait_xy(9, 0);
    chk("align first blank", VGA_R, 0);
    wait_xy(8, 2);
    chk("align R x=7", VGA_R, 7);
    wait_sig(2, 1'b1, 1000);
    chk("restart frame period", cyc - t, 240);
    chk("restart FrameCount", FrameCount, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock.
- Drives the DrawX/DrawY pixel coordinates consumed by the colour mapper.
- Takes back the mapper's combinational RGB and registers it, together with the syncs and blank, into one aligned output stage for the DAC.
- Also issues a per-frame strobe and a frame counter for animation and state updates.

Parameters:
- CLK_DIV, 2: Clk cycles per pixel; must be an even value ≥2.
- H_VISIBLE, 640: active pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: active lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BACK, 33: vertical back porch, in lines.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous active-low reset.
- Pix_R, Pix_G, Pix_B  in  8 each  colour for the current DrawX/DrawY, from the colour mapper (combinational).
- DrawX  out  10  current horizontal counter.
- DrawY  out  10  current vertical counter.
- PixEn  out  1  one-Clk pixel-advance strobe.
- VGA_Clk  out  1  pixel clock to the DAC.
- VGA_HS  out  1  horizontal sync, active-low.
- VGA_VS  out  1  vertical sync, active-low.
- VGA_Blank_n  out  1  low outside the visible area.
- VGA_R, VGA_G, VGA_B  out  8 each  registered colour.
- FrameStart  out  1  one-Clk pulse at end of frame.
- FrameCount  out  8  frames elapsed; wraps.

Behaviour:
- Derived constants:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (800).
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (525).
- Reset (asynchronous, Reset_n=0) forces:
  - div_cnt=0, hc=0, vc=0, PixEn=0, VGA_Clk=0.
  - VGA_HS=1, VGA_VS=1, VGA_Blank_n=0.
  - VGA_R/G/B=0, FrameStart=0, FrameCount=0.
  - Release is synchronous-safe: the first div_cnt increment occurs on the first Clk edge after deassertion.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - PixEn is combinational, equal to (div_cnt==CLK_DIV-1).
  - VGA_Clk is a register; it is high exactly while div_cnt ≥ CLK_DIV/2 and is glitch-free.
- Counters (advance only on Clk edges where PixEn=1):
  - hc increments; at H_TOTAL-1 it wraps to 0 and vc increments.
  - vc wraps from V_TOTAL-1 to 0 on the same edge that hc wraps.
  - DrawX=hc and DrawY=vc, taken directly from the registers. They are stable for CLK_DIV Clk cycles.
- Output stage (updates only on Clk edges where PixEn=1; otherwise all outputs hold):
  - visible = (hc < H_VISIBLE) && (vc < V_VISIBLE).
  - VGA_R/G/B ← Pix_R/G/B when visible, else 0. Blanked colour must be exactly 0 regardless of mapper output.
  - VGA_Blank_n ← visible.
  - VGA_HS ← ~(hc in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]), i.e. low for hc 656..751.
  - VGA_VS ← ~(vc in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]), i.e. low for vc 490..491.
  - Latency: colour, syncs and blank for pixel (hc,vc) all appear together one pixel period after DrawX/DrawY present (hc,vc). All four are mutually aligned.
- Frame strobe:
  - FrameStart=1 for exactly one Clk, on the edge where PixEn=1, hc=H_TOTAL-1 and vc=V_TOTAL-1 (registered; high during the cycle after that edge).
  - FrameCount increments on that same edge and wraps 255→0.
- Frame timing:
  - Frame period = H_TOTAL × V_TOTAL × CLK_DIV = 840000 Clk cycles.
  - Line period = 1600 Clk cycles.
- Reset mid-frame: every output returns to its reset value immediately, with no partial sync pulse held. The raster restarts at (0,0).

Test Plan:
- Reset release: hold Reset_n=0 for 5 Clk, then release.
  - Required: DrawX=0, DrawY=0, VGA_HS=1, VGA_VS=1, VGA_Blank_n=0, RGB=0.
  - Required: PixEn pulses every 2nd Clk.
  - Required: DrawX=1 after the first PixEn edge.
- Hsync timing:
  - Required: VGA_HS falls exactly 657 PixEn strobes after DrawX=0 (registered value for hc=656).
  - Required: VGA_HS stays low for 96 strobes (192 Clk).
  - Required: line period is 1600 Clk.
- Vsync and frame:
  - Required: VGA_VS is low for exactly 2 lines (3200 Clk), starting with line 490.
  - Required: FrameStart pulses once per 840000 Clk, one Clk wide.
  - Required: FrameCount 255→0 after 256 frames.
- Colour pass-through and blanking:
  - Drive Pix_R/G/B=8'hd7/1c/1c constantly.
  - Required: VGA_R/G/B = d7/1c/1c with VGA_Blank_n=1 for hc<640 and vc<480.
  - Required: outputs 0 at hc 640..799 and on vc ≥480.
  - Required: output lags DrawX by one pixel.
- Alignment check:
  - Drive Pix_R = DrawX[7:0] from the bench.
  - Required: VGA_R equals the previous DrawX[7:0] at every PixEn in the visible area; 0 at the first blank pixel (hc=640).
- Mid-frame reset: assert Reset_n=0 at hc=700, vc=491 (VGA_HS=0, VGA_VS=0).
  - Required: within the same cycle VGA_HS=1, VGA_VS=1, counters 0, FrameCount 0.
  - Required: after release, normal timing resumes from (0,0).
